sym_stream_sched: RTL and testbench

Two-channel scheduler that shares a single 2-bit symbol-sequence detector between two requesters. A requester asks for a burst of N symbols. The scheduler grants the detector to one requester at a time, round-robin, and feeds it that requester's symbols. It also keeps a per-channel saturating count of pattern matches. The block sits between the symbol sources and the status/readout logic.

---
 rtl/sym_stream_sched_pkg.sv | 25 ++
 rtl/sym_match_fsm.sv | 50 +++++
 rtl/sym_stream_sched.sv | 108 ++++++++++
 tb/tb_sym_stream_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_stream_sched_pkg.sv
// Shared encodings for the symbol-stream scheduler and its pattern detector.
package sym_stream_sched_pkg;

  localparam logic [1:0] SYM_0 = 2'd0;
  localparam logic [1:0] SYM_1 = 2'd1;
  localparam logic [1:0] SYM_2 = 2'd2;
  localparam logic [1:0] SYM_3 = 2'd3;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  function automatic logic [1:0] chan_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sym_match_fsm.sv
// Detects symbol runs of the form 1+ 2+ 3+; match is flagged combinationally
// for the symbol being consumed when it drives the detector into S3.
module sym_match_fsm
  import sym_stream_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] num,
  output logic       match
);

  det_state_t state;
  det_state_t nxt;

  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = (num == SYM_1) ? S1 : S0;
      S1: begin
        if (num == SYM_1)      nxt = S1;
        else if (num == SYM_2) nxt = S2;
        else                   nxt = S0;
      end
      S2: begin
        case (num)
          SYM_1:   nxt = S1;
          SYM_2:   nxt = S2;
          SYM_3:   nxt = S3;
          default: nxt = S0;
        endcase
      end
      S3: begin
        if (num == SYM_1)      nxt = S1;
        else if (num == SYM_3) nxt = S3;
        else                   nxt = S0;
      end
      default: nxt = S0;
    endcase
  end

  assign match = en && (nxt == S3);

  always_ff @(posedge clk) begin
    if (reset || clr) state <= S0;
    else if (en)      state <= nxt;
  end

endmodule

// File: rtl/sym_stream_sched.sv
// Round-robin two-channel burst scheduler sharing one pattern detector, with
// per-channel saturating match counters and a done pulse per burst.
module sym_stream_sched
  import sym_stream_sched_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [1:0]       sym0,
  input  logic [1:0]       sym1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic             done,
  output logic             done_id
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  sched_state_t     state;
  logic             owner;
  logic             ptr;
  logic [LEN_W-1:0] rem;
  logic [1:0]       elig;
  logic             winner;
  logic [1:0]       cur_sym;
  logic             det_clr;
  logic             det_en;
  logic             match;

  assign elig = {req[1] && (len1 != '0), req[0] && (len0 != '0)};

  // On a tie the channel that was not served last wins.
  always_comb begin
    winner = elig[1];
    if (elig == 2'b11) winner = ~ptr;
  end

  assign cur_sym = owner ? sym1 : sym0;
  assign det_clr = (state == IDLE);
  assign det_en  = (state == RUN);
  assign busy    = |gnt;

  sym_match_fsm u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .en    (det_en),
    .num   (cur_sym),
    .match (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b1;
      rem      <= '0;
      gnt      <= 2'b00;
      hit      <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      hit_cnt0 <= '0;
      hit_cnt1 <= '0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|elig) begin
            state <= RUN;
            owner <= winner;
            ptr   <= winner;
            rem   <= winner ? len1 : len0;
            gnt   <= chan_onehot(winner);
          end
        end
        RUN: begin
          hit <= match;
          if (match) begin
            if (owner) hit_cnt1 <= sat_inc(hit_cnt1);
            else       hit_cnt0 <= sat_inc(hit_cnt0);
          end
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            done    <= 1'b1;
            done_id <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_stream_sched.sv
// Bench for sym_stream_sched: a burst-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sym_stream_sched;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic [1:0]       sym0 = 2'd0;
  logic [1:0]       sym1 = 2'd0;

  logic [1:0] gnt;
  logic       busy, hit, done, done_id;
  logic [7:0] hit_cnt0, hit_cnt1;

  logic [1:0] s_gnt;
  logic       s_busy, s_hit, s_done, s_done_id;
  logic [1:0] s_cnt0, s_cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sym_stream_sched #(.LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .sym0(sym0), .sym1(sym1), .gnt(gnt), .busy(busy), .hit(hit),
    .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1), .done(done), .done_id(done_id)
  );

  sym_stream_sched #(.LEN_W(LEN_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .sym0(sym0), .sym1(sym1), .gnt(s_gnt), .busy(s_busy), .hit(s_hit),
    .hit_cnt0(s_cnt0), .hit_cnt1(s_cnt1), .done(s_done), .done_id(s_done_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: burst-level behaviour with the symbol history of the
  // current burst, matched against 1+ 2+ 3+ by scanning it backwards.
  bit m_run = 0;
  int m_owner = 0, m_rem = 0, m_ptr = 1;
  bit m_hit = 0, m_done = 0, m_done_id = 0;
  int m_c0 = 0, m_c1 = 0, m_s0 = 0, m_s1 = 0;
  int hist[$];

  function automatic bit pat_end(input int q[$]);
    int i = q.size() - 1;
    int n3 = 0, n2 = 0, n1 = 0;
    while (i >= 0 && q[i] == 3) begin n3++; i--; end
    while (i >= 0 && q[i] == 2) begin n2++; i--; end
    while (i >= 0 && q[i] == 1) begin n1++; i--; end
    return (n3 > 0) && (n2 > 0) && (n1 > 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_owner = 0; m_rem = 0; m_ptr = 1;
      m_hit = 0; m_done = 0; m_done_id = 0;
      m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
      hist.delete();
    end else begin
      m_hit = 0;
      m_done = 0;
      if (m_run) begin
        hist.push_back(m_owner == 1 ? int'(sym1) : int'(sym0));
        if (pat_end(hist)) begin
          m_hit = 1;
          if (m_owner == 0) begin
            if (m_c0 < 255) m_c0++;
            if (m_s0 < 3) m_s0++;
          end else begin
            if (m_c1 < 255) m_c1++;
            if (m_s1 < 3) m_s1++;
          end
        end
        m_rem--;
        if (m_rem == 0) begin
          m_run = 0;
          m_done = 1;
          m_done_id = (m_owner == 1);
        end
      end else begin
        bit e0, e1;
        e0 = req[0] && (len0 != 0);
        e1 = req[1] && (len1 != 0);
        if (e0 || e1) begin
          if (e0 && e1) m_owner = 1 - m_ptr;
          else m_owner = e1 ? 1 : 0;
          m_ptr = m_owner;
          m_rem = (m_owner == 1) ? int'(len1) : int'(len0);
          m_run = 1;
          hist.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    eg = m_run ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt", gnt, eg);
    chk("busy", busy, m_run);
    chk("hit", hit, m_hit);
    chk("done", done, m_done);
    if (m_done) chk("done_id", done_id, m_done_id);
    chk("hit_cnt0", hit_cnt0, m_c0);
    chk("hit_cnt1", hit_cnt1, m_c1);
    chk("sat_gnt", s_gnt, eg);
    chk("sat_ctl", {s_busy, s_hit, s_done}, {m_run, m_hit, m_done});
    if (m_done) chk("sat_done_id", s_done_id, m_done_id);
    chk("sat_cnt0", s_cnt0, m_s0);
    chk("sat_cnt1", s_cnt1, m_s1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_sym(input int ch, input logic [1:0] s);
    if (ch == 0) begin sym0 = s; sym1 = 2'd3; end
    else begin sym1 = s; sym0 = 2'd3; end
  endtask

  // Requests a burst on ch (with request mask rq), feeds n packed symbols
  // (symbol i in bits [2i+1:2i]) and checks the trailing done pulse.
  task automatic burst(input logic [1:0] rq, input int ch, input int n,
                       input logic [31:0] syms, input string nm);
    int w = 0;
    logic [3:0] l;
    l = n[3:0];
    req = rq;
    if (ch == 0) len0 = l; else len1 = l;
    set_sym(ch, syms[1:0]);
    tick();
    while (gnt[ch] !== 1'b1 && w < 8) begin tick(); w++; end
    if (gnt[ch] !== 1'b1) begin
      chk({nm, "_grant_timeout"}, gnt, (ch == 1) ? 2 : 1);
      req = 2'b00;
      return;
    end
    req = 2'b00;
    for (int i = 0; i < n; i++) begin
      set_sym(ch, syms[2*i +: 2]);
      tick();
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_done_id"}, done_id, ch);
  endtask

  initial begin
    logic [1:0] pat [7];
    pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    do_reset();
    chk("reset_gnt", gnt, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt0", hit_cnt0, 0);

    // Basic 1,2,3 burst on channel 0.
    burst(2'b01, 0, 3, 32'd57, "t1");
    chk("t1_hit", hit, 1);
    chk("t1_cnt0", hit_cnt0, 1);
    tick();

    // Both channels held with len 1: alternating grants with an idle gap.
    do_reset();
    len0 = 4'd1; len1 = 4'd1; req = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_rr_gnt", gnt, pat[i]);
    end
    req = 2'b00;
    tick(); tick();

    // Channel 1: 1,1,2,3,3,0 gives two hits.
    do_reset();
    burst(2'b10, 1, 6, 32'd997, "t3");
    chk("t3_cnt1", hit_cnt1, 2);
    tick();

    // Isolation across bursts and channels.
    do_reset();
    burst(2'b01, 0, 2, 32'd9, "t4a");
    burst(2'b10, 1, 1, 32'd3, "t4b");
    burst(2'b01, 0, 1, 32'd3, "t4c");
    chk("t4_cnt0", hit_cnt0, 0);
    chk("t4_cnt1", hit_cnt1, 0);
    tick();

    // Zero-length request on channel 0 is never granted.
    do_reset();
    len0 = 4'd0;
    burst(2'b11, 1, 2, 32'd9, "t5");
    tick();

    // Saturation: 1,2,3,3,3,3,3,0,0,0 gives five matches.
    do_reset();
    burst(2'b01, 0, 10, 32'd16377, "t6");
    chk("t6_cnt0_w8", hit_cnt0, 5);
    chk("t6_cnt0_w2", s_cnt0, 3);
    tick();

    // Reset mid-burst aborts without a done pulse.
    do_reset();
    len0 = 4'd5; req = 2'b01; set_sym(0, 2'd1);
    tick();
    chk("t7_gnt", gnt, 1);
    req = 2'b00;
    tick();
    set_sym(0, 2'd2);
    tick();
    set_sym(0, 2'd3);
    tick();
    chk("t7_pre_cnt0", hit_cnt0, 1);
    reset = 1'b1;
    tick();
    chk("t7_abort_gnt", gnt, 0);
    chk("t7_abort_cnt0", hit_cnt0, 0);
    chk("t7_abort_done", done, 0);
    reset = 1'b0;
    tick();
    chk("t7_no_done", done, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
